// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: output bundle of the VGA timing generator.
interface vga_sync_gen_if #(parameter int CW = 12);
  logic          hsync, vsync, de, pix_tick, line_start, frame_start;
  logic [CW-1:0] pixel_x, pixel_y;
  logic [11:0]   rgb;
  modport master (output hsync, vsync, de, pix_tick, line_start, frame_start, pixel_x, pixel_y, rgb);
  modport slave  (input  hsync, vsync, de, pix_tick, line_start, frame_start, pixel_x, pixel_y, rgb);
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: parametrised VGA sync/DE/coordinate generator with prescaled pixel enable.
// Define VGA_SYNC_PATTERN_EN to drive rgb with eight vertical colour bars.
module vga_sync_gen #(
  parameter int CLK_DIV = 4,
  parameter int CW      = 12,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int H_DISP  = 640,
  parameter int H_FP    = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int V_DISP  = 480,
  parameter int V_FP    = 10,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0
) (
  input logic            clk,
  input logic            reset_n,
  vga_sync_gen_if.master o_vga
);
  localparam int H_TOTAL = H_SYNC + H_BP + H_DISP + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_DISP + V_FP;
  localparam int DW      = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [1:0] {SYNC, BACK, DISP, FRONT} seg_e;
  logic [DW-1:0] r_div, w_div;
  logic [CW-1:0] r_h, r_v, w_h, w_v, w_hlast, w_vlast, w_px, w_py, r_px, r_py;
  seg_e          r_hst, r_vst, w_hst, w_vst;
  logic          w_tick, w_hwrap, w_vwrap, w_de;
  logic          r_hsync, r_vsync, r_de, r_tick, r_ls, r_fs;
  always_comb begin
    w_tick  = r_div == DW'(CLK_DIV - 1);
    w_div   = w_tick ? '0 : r_div + DW'(1);
    w_hwrap = w_tick && r_h == CW'(H_TOTAL - 1);
    w_vwrap = w_hwrap && r_v == CW'(V_TOTAL - 1);
    w_h     = w_hwrap ? '0 : r_h + CW'(w_tick);
    w_v     = w_vwrap ? '0 : r_v + CW'(w_hwrap);
    w_hlast = CW'(r_hst == SYNC ? H_SYNC - 1 : r_hst == BACK ? H_SYNC + H_BP - 1 :
                  r_hst == DISP ? H_SYNC + H_BP + H_DISP - 1 : H_TOTAL - 1);
    w_vlast = CW'(r_vst == SYNC ? V_SYNC - 1 : r_vst == BACK ? V_SYNC + V_BP - 1 :
                  r_vst == DISP ? V_SYNC + V_BP + V_DISP - 1 : V_TOTAL - 1);
    w_hst   = (w_tick && r_h == w_hlast) ? seg_e'(r_hst + 2'd1) : r_hst;
    w_vst   = (w_hwrap && r_v == w_vlast) ? seg_e'(r_vst + 2'd1) : r_vst;
    w_de    = w_hst == DISP && w_vst == DISP;
    w_px    = w_de ? w_h - CW'(H_SYNC + H_BP) : '0;
    w_py    = w_vst == DISP ? w_v - CW'(V_SYNC + V_BP) : '0;
  end
  // Outputs are registered from next-state values so they line up with the counters.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_div   <= '0;
      r_h     <= '0;
      r_v     <= '0;
      r_hst   <= SYNC;
      r_vst   <= SYNC;
      r_hsync <= HS_POL;
      r_vsync <= VS_POL;
      r_de    <= 1'b0;
      r_px    <= '0;
      r_py    <= '0;
      r_tick  <= 1'b0;
      r_ls    <= 1'b0;
      r_fs    <= 1'b0;
    end else begin
      r_div   <= w_div;
      r_h     <= w_h;
      r_v     <= w_v;
      r_hst   <= w_hst;
      r_vst   <= w_vst;
      r_hsync <= w_hst == SYNC ? HS_POL : ~HS_POL;
      r_vsync <= w_vst == SYNC ? VS_POL : ~VS_POL;
      r_de    <= w_de;
      r_px    <= w_px;
      r_py    <= w_py;
      r_tick  <= w_div == DW'(CLK_DIV - 1);
      r_ls    <= w_hwrap;
      r_fs    <= w_vwrap;
    end
  assign o_vga.hsync       = r_hsync;
  assign o_vga.vsync       = r_vsync;
  assign o_vga.de          = r_de;
  assign o_vga.pixel_x     = r_px;
  assign o_vga.pixel_y     = r_py;
  assign o_vga.pix_tick    = r_tick;
  assign o_vga.line_start  = r_ls;
  assign o_vga.frame_start = r_fs;
`ifdef VGA_SYNC_PATTERN_EN
  localparam logic [CW+2:0] HD = (CW + 3)'(H_DISP);
  logic [2:0]  w_bar;
  logic [11:0] r_rgb;
  assign w_bar = 3'({w_px, 3'b000} / HD);
  // Bar index bits map directly to colour: bit1 clears red, bit2 green, bit0 blue.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_rgb <= '0;
    else          r_rgb <= w_de ? {{4{~w_bar[1]}}, {4{~w_bar[2]}}, {4{~w_bar[0]}}} : '0;
  assign o_vga.rgb = r_rgb;
`else
  assign o_vga.rgb = 12'h000;
`endif
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

- Parametrised VGA timing generator.
- Produces horizontal and vertical sync, display-enable, pixel coordinates and line/frame strobes from a single system clock.
- Pixel clock is an internal clock-enable derived by an integer prescaler.
- Sits between the system clock and the pixel/frame-buffer read logic; generalises the fixed 640x480 horizontal-only sync FSM to both axes, any timing and either sync polarity.

## Interface
- `CLK_DIV`, default 4: system clocks per pixel (>=1).
- `CW`, default 12: width of the internal counters and coordinates.
- `H_SYNC`, `H_BP`, `H_DISP`, `H_FP`, defaults 96, 48, 640, 16: horizontal segment lengths in pixels.
- `V_SYNC`, `V_BP`, `V_DISP`, `V_FP`, defaults 2, 33, 480, 10: vertical segment lengths in lines.
- `HS_POL`, default 0: active level of `hsync` (0 = active-low).
- `VS_POL`, default 0: active level of `vsync`.
- Constraints: every segment length >= 1; `H_*` sum (H_TOTAL) and `V_*` sum (V_TOTAL) each <= 2^CW.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `hsync`  out  1  horizontal sync, level per `HS_POL`.
- `vsync`  out  1  vertical sync, level per `VS_POL`.
- `de`  out  1  high while both axes are in their display segment.
- `pixel_x`  out  CW  column 0..H_DISP-1 while `de`, else 0.
- `pixel_y`  out  CW  row 0..V_DISP-1 while vertical display, else 0.
- `pix_tick`  out  1  one-clk pulse: pixel boundary (clock enable for downstream).
- `line_start`  out  1  one-clk pulse when a new line begins.
- `frame_start`  out  1  one-clk pulse when a new frame begins.
- `rgb`  out  12  test-pattern colour, {R4,G4,B4}.

## Operation
- Prescaler `div_cnt` counts 0..CLK_DIV-1 and wraps; `pix_tick` = (`div_cnt` == CLK_DIV-1). With CLK_DIV=1, `pix_tick` is constantly 1 after reset.
- `h_cnt` advances 0..H_TOTAL-1 on `pix_tick`; at H_TOTAL-1 with `pix_tick` it wraps to 0.
- `v_cnt` advances only on that wrap; it wraps 0 after V_TOTAL-1.
- Horizontal Moore FSM SYNC -> BACK -> DISP -> FRONT -> SYNC. Each transition occurs on `pix_tick` when `h_cnt` equals the last pixel of the current segment:
  - SYNC exits at H_SYNC-1.
  - BACK exits at H_SYNC+H_BP-1.
  - DISP exits at H_SYNC+H_BP+H_DISP-1.
  - FRONT exits at H_TOTAL-1.
- Vertical FSM has the same four states with `V_*` boundaries, advancing only on the line wrap.
- `hsync` = HS_POL in SYNC, else ~HS_POL; `vsync` likewise.
- `de` = horizontal DISP && vertical DISP.
- `pixel_x` = `h_cnt`-(H_SYNC+H_BP) in DISP, else 0; `pixel_y` analogous.
- `line_start` pulses on the edge where `h_cnt` wraps to 0; `frame_start` on the edge where both `h_cnt` and `v_cnt` wrap to 0. They coincide then.
- All outputs are registered (driven from flops); no combinational path from inputs.

## Timing
- Reset values:
  - `div_cnt`=0, `h_cnt`=0, `v_cnt`=0, both FSMs in SYNC.
  - `hsync`=HS_POL, `vsync`=VS_POL.
  - `de`=0, `pixel_x`=0, `pixel_y`=0.
  - `pix_tick`=0, `line_start`=0, `frame_start`=0, `rgb`=0.
- Reset assertion mid-line or mid-frame returns all state to reset values immediately. The first frame after release begins in SYNC with no `frame_start` pulse; the first pulse comes at the end of that frame.
- Line period = H_TOTAL*CLK_DIV clks; frame period = V_TOTAL*H_TOTAL*CLK_DIV clks. Defaults: 3200 and 1,680,000.
- `hsync`, `de`, `pixel_x` change only on the edge following a `pix_tick` cycle. Each pixel value is stable for exactly CLK_DIV clks.
- Segment boundaries are exact:
  - Horizontal SYNC lasts H_SYNC*CLK_DIV clks (default 384, matching counts 0..383).
  - Horizontal DISP starts at clk 576 after line start and ends after clk 3135.
- Last pixel of the frame (h=H_TOTAL-1, v=V_TOTAL-1): both counters wrap on the same edge, and `line_start` and `frame_start` both assert.

## Configuration
- `VGA_SYNC_PATTERN_EN` defined: `rgb` = 8 vertical colour bars, bar index = `pixel_x`[*] scaled to H_DISP/8 (bar = `pixel_x`*8/H_DISP).
  - Colour order white, yellow, cyan, green, magenta, red, blue, black (full-scale nibbles).
  - `rgb`=0 whenever `de`=0. Registered with the same timing as `pixel_x`.
- Not defined: `rgb` tied to 12'h000 and no pattern logic synthesised.

## Test plan
- Defaults, release reset: `hsync` low for 384 clks, then high; `de` rises only in line 35 at clk 576 of the line; line period 3200 clks.
- CLK_DIV=1, H 2/1/4/1, V 1/1/2/1 (HS_POL=VS_POL=0): `pixel_x` sequence 0,1,2,3 with `de` high on h_cnt 3..6 of rows 2..3 only; `frame_start` every 40 clks.
- HS_POL=1, VS_POL=1: `hsync`/`vsync` are exact inversions of the default-polarity run, cycle for cycle.
- Assert `reset_n` low for 3 clks mid-display (`pixel_x`=100): all outputs reach reset values asynchronously; restart matches a fresh-reset trace.
- Frame wrap at h=H_TOTAL-1, v=V_TOTAL-1: `line_start` and `frame_start` both high for exactly one clk; `v_cnt` returns to 0.
- With `VGA_SYNC_PATTERN_EN`: pixel_x=0 -> `rgb`=FFF, pixel_x=80 -> FF0, pixel_x=560 -> 000, blanking -> 000.
